multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified instruction/data memory, and the source muxes in front of them, including the ALU B-source mux. Each cycle it decodes the latched instruction fields and state into mux selects, write enables and the ALU operation. It also stalls on a memory ready handshake. It sits between the instruction register and the datapath muxes, replacing the single-cycle main decoder.

## Interface
- `PERF_W`, default 32: width of the performance counters. Used only when `MCTRL_PERF_EN` is defined.

- `clk_i` input 1: single clock; all state changes on its rising edge.
- `rst_ni` input 1: synchronous, active-low reset.
- `op_i` input 7: opcode field, instr[6:0].
- `funct3_i` input 3: instr[14:12].
- `funct7b5_i` input 1: instr[30].
- `zero_i` input 1: ALU zero flag.
- `mem_ready_i` input 1: memory has completed the current access.
- `pc_write_o` output 1: PC register load enable.
- `ir_write_o` output 1: instruction register and old-PC load enable.
- `adr_src_o` output 1: memory address select; 0 = PC, 1 = ALU out.
- `mem_write_o` output 1: memory write strobe.
- `reg_write_o` output 1: register file write enable.
- `alu_src_a_o` output 2: ALU A select; 00 = PC, 01 = old PC, 10 = rd1.
- `alu_src_b_o` output 2: ALU B select; 00 = rd2, 01 = imm_ext, 10 = constant 4.
- `result_src_o` output 2: result select; 00 = ALU out register, 01 = memory data, 10 = ALU result.
- `alu_ctrl_o` output 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_o` output 1: an unsupported opcode has been decoded.
- `instret_o` output PERF_W: retired-instruction count. Present only with `MCTRL_PERF_EN`.
- `cycle_o` output PERF_W: cycles since reset. Present only with `MCTRL_PERF_EN`.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BEQ, ILLEGAL.
- In every state, any output not listed for that state is 0.
- FETCH
  - Drives: adr_src=0, a=00, b=10, add, result_src=10.
  - When mem_ready_i=1: ir_write_o=1 and pc_write_o=1, then go to DECODE.
  - Otherwise stay in FETCH with both enables at 0.
- DECODE
  - Drives: a=01, b=01, add. This precomputes the branch/jump target.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1101111 → JAL.
    - 1100011 → BEQ.
    - Anything else → ILLEGAL.
- MEMADR
  - Drives: a=10, b=01, add.
  - Next state: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD
  - Drives: adr_src=1, result_src=00.
  - Holds until mem_ready_i=1, then goes to MEMWB.
- MEMWB
  - Drives: result_src=01, reg_write=1.
  - Next state: FETCH.
- MEMWRITE
  - Drives: adr_src=1, result_src=00, mem_write=1.
  - mem_write stays at 1 every cycle until mem_ready_i=1, then go to FETCH.
- EXEC_R
  - Drives: a=10, b=00, ALU op from the R decode.
  - Next state: ALUWB.
- EXEC_I
  - Drives: a=10, b=01, ALU op from the I decode.
  - Next state: ALUWB.
- ALUWB
  - Drives: result_src=00, reg_write=1.
  - Next state: FETCH.
- JAL
  - Drives: a=01, b=10, add, result_src=00, pc_write=1.
  - Next state: ALUWB, which writes the link value.
- BEQ
  - Drives: a=10, b=00, sub, result_src=00, pc_write_o=zero_i.
  - Next state: FETCH.
- ILLEGAL
  - illegal_o=1; all enables are 0.
  - The FSM stays in ILLEGAL until reset.
- ALU op decode (EXEC_R/EXEC_I only):
  - funct3=000: add. It is sub only when op_i[5]=1 and funct7b5_i=1; addi is never sub.
  - funct3=010: slt.
  - funct3=110: or.
  - funct3=111: and.
  - Other funct3 values: add.

## Timing
- State register updates on the clk_i rising edge.
- Outputs are combinational from state. The only exceptions are pc_write_o and ir_write_o, which also depend on mem_ready_i and zero_i.
- Reset:
  - rst_ni=0 at a clock edge puts the state to FETCH and clears the counters.
  - While rst_ni=0, all enable outputs are forced to 0 and illegal_o=0.
  - Mux selects show their FETCH values.
  - Reset mid-instruction, including during MEMWRITE with mem_write asserted, aborts the instruction; it is not retired.
- Minimum latency per instruction, with mem_ready_i tied to 1:
  - beq: 3 cycles.
  - R, I and jal: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Each memory-wait cycle adds exactly 1 cycle.
- mem_ready_i has no effect outside FETCH, MEMREAD and MEMWRITE.

## Configuration
- `MCTRL_PERF_EN` defined:
  - `cycle_o` increments every cycle out of reset.
  - `instret_o` increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters wrap modulo 2^PERF_W.
  - Neither counter advances while in ILLEGAL, except that `cycle_o` keeps counting.
- `MCTRL_PERF_EN` undefined: both ports and both counters are absent. The FSM behaviour is identical.

## Test plan
- add (op 0110011, funct3 000, f7b5 0), mem_ready_i=1 → state sequence FETCH, DECODE, EXEC_R, ALUWB. alu_ctrl_o=000 in EXEC_R; reg_write_o=1 only in ALUWB.
- lw with mem_ready_i low for 2 cycles in MEMREAD → MEMREAD lasts 3 cycles; result_src_o=01 and reg_write_o=1 in MEMWB; total 7 cycles.
- beq with zero_i=1, then again with zero_i=0 → pc_write_o=1 in BEQ for the first and 0 for the second; alu_ctrl_o=001 in both.
- sw with mem_ready_i delayed 3 cycles → mem_write_o=1 and adr_src_o=1 for 4 consecutive cycles, then FETCH.
- op_i=0000000 → ILLEGAL; illegal_o=1 held for 10 cycles; rst_ni=0 for one edge → FETCH, illegal_o=0.
- With `MCTRL_PERF_EN`, PERF_W=4, execute 17 add instructions → instret_o=1 (wrapped).

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore-style control FSM for a shared multicycle RV32I
// datapath (one ALU, one unified instruction/data memory). Decodes the latched
// opcode/funct fields plus the current state into mux selects, write enables
// and the ALU operation, and stalls FETCH/MEMREAD/MEMWRITE on mem_ready_i.
//
// Optional feature: define MCTRL_PERF_EN to add the cycle_o and instret_o
// performance counters (PERF_W bits wide, wrapping).
//
// Handshake: mem_ready_i is a per-cycle completion flag for the access the
// FSM is currently presenting (valid = being in FETCH, MEMREAD or MEMWRITE);
// the access is complete in the cycle where valid and ready are both 1, and
// the FSM holds the access (and mem_write_o) steady until then.
//
// dbg_state_o exposes the raw state register for checkers.
module multicycle_controller #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [6:0]        op_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic              zero_i,
  input  logic              mem_ready_i,
  output logic              pc_write_o,
  output logic              ir_write_o,
  output logic              adr_src_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic [1:0]        alu_src_a_o,
  output logic [1:0]        alu_src_b_o,
  output logic [1:0]        result_src_o,
  output logic [2:0]        alu_ctrl_o,
  output logic              illegal_o,
`ifdef MCTRL_PERF_EN
  output logic [PERF_W-1:0] instret_o,
  output logic [PERF_W-1:0] cycle_o,
`endif
  output logic [3:0]        dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state;
  state_t state_next;

  // ALU operation for EXEC_R/EXEC_I; op_i[5] separates R from I so addi
  // can never become a subtract.
  function automatic logic [2:0] alu_decode(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [2:0] ctrl;
    case (f3)
      3'b000:  ctrl = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctrl = ALU_SLT;
      3'b110:  ctrl = ALU_OR;
      3'b111:  ctrl = ALU_AND;
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

  // State register: synchronous active-low reset back to FETCH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready_i) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) state_next = S_FETCH;
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_BEQ:      state_next = S_FETCH;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode from state; reset forces enables off and FETCH selects.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    alu_ctrl_o   = ALU_ADD;
    illegal_o    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_write_o   = mem_ready_i;
        ir_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b00;
        alu_ctrl_o  = alu_decode(op_i, funct3_i, funct7b5_i);
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_ctrl_o  = alu_decode(op_i, funct3_i, funct7b5_i);
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b00;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = zero_i;
      end
      S_ILLEGAL: begin
        illegal_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b0;
      end
    endcase
    if (!rst_ni) begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      illegal_o    = 1'b0;
      adr_src_o    = 1'b0;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b10;
      result_src_o = 2'b10;
      alu_ctrl_o   = ALU_ADD;
    end
  end

  assign dbg_state_o = state;

`ifdef MCTRL_PERF_EN
  // An instruction retires on the edge that takes it back into FETCH.
  logic retire;
  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready_i);

  // Free-running cycle counter and retired-instruction counter, both wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycle_o   <= '0;
      instret_o <= '0;
    end else begin
      cycle_o <= cycle_o + PERF_W'(1);
      if (retire) instret_o <= instret_o + PERF_W'(1);
    end
  end
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Each instruction is expanded into its
// expected per-cycle output vectors (from the per-state output tables) along
// with the per-cycle mem_ready/reset stimulus; a driver plays the queues and a
// single compare process checks every cycle on the falling edge.
module tb_multicycle_controller;

  localparam int PW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, adr_src_o, mem_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
  logic [2:0] alu_ctrl_o;
  logic       illegal_o;
  logic [3:0] dbg_state;
`ifdef MCTRL_PERF_EN
  logic [PW-1:0] instret_o, cycle_o;
`endif

  multicycle_controller #(.PERF_W(PW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .adr_src_o    (adr_src_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .result_src_o (result_src_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .illegal_o    (illegal_o),
`ifdef MCTRL_PERF_EN
    .instret_o    (instret_o),
    .cycle_o      (cycle_o),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Output vector: {pcw, irw, adr, mw, rw, a[1:0], b[1:0], res[1:0], alu[2:0], ill}
  logic [14:0] dut_vec;
  assign dut_vec = {pc_write_o, ir_write_o, adr_src_o, mem_write_o, reg_write_o,
                    alu_src_a_o, alu_src_b_o, result_src_o, alu_ctrl_o, illegal_o};

  logic [14:0] exp_q[$];
  logic        rdy_q[$];
  logic        rstn_q[$];
  logic        ret_q[$];
  logic [11:0] fld_q[$];
  logic [11:0] bld_fld;

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk = 1'b0;
  logic [14:0] cur_exp;
  logic        cur_ret;
`ifdef MCTRL_PERF_EN
  logic [PW-1:0] m_cyc = '0;
  logic [PW-1:0] m_ret = '0;
  logic          perf_valid = 1'b0;
`endif

  function automatic logic [14:0] v(input logic pcw, input logic irw, input logic adr,
                                    input logic mw, input logic rw, input logic [1:0] a,
                                    input logic [1:0] b, input logic [1:0] res,
                                    input logic [2:0] alu, input logic ill);
    return {pcw, irw, adr, mw, rw, a, b, res, alu, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ALU operation an R/I instruction must produce.
  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && op == OP_R && f7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
           op == OP_JAL || op == OP_BEQ;
  endfunction

  task automatic push(input logic [14:0] e, input logic r, input logic rn, input logic rt);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    rstn_q.push_back(rn);
    ret_q.push_back(rt);
    fld_q.push_back(bld_fld);
  endtask

  task automatic pin(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expand one instruction into expected cycles. fw = fetch wait cycles,
  // mw = memory wait cycles, ic = ILLEGAL cycles before reset, abort = reset
  // a store in the middle of MEMWRITE.
  task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input int fw, input int mw, input int ic,
                     input bit abort);
    logic [14:0] rst_v;
    logic [14:0] aluwb_v;
    rst_v   = v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    aluwb_v = v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    bld_fld = {op, f3, f7, z};
    for (int i = 0; i < fw; i++) push(rst_v, 1'b0, 1'b1, 1'b0);
    push(v(1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0), 1'b1, 1'b1, 1'b0);
    push(v(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 0), rb(), 1'b1, 1'b0);
    if (op == OP_LW) begin
      push(v(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0), rb(), 1'b1, 1'b0);
      for (int i = 0; i < mw; i++)
        push(v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), 1'b0, 1'b1, 1'b0);
      push(v(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), 1'b1, 1'b1, 1'b0);
      push(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 0), rb(), 1'b1, 1'b1);
    end else if (op == OP_SW) begin
      push(v(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0), rb(), 1'b1, 1'b0);
      for (int i = 0; i < mw; i++)
        push(v(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), 1'b0, 1'b1, 1'b0);
      if (abort) push(rst_v, rb(), 1'b0, 1'b0);
      else push(v(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0), 1'b1, 1'b1, 1'b1);
    end else if (op == OP_R) begin
      push(v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, exp_alu(op, f3, f7), 0), rb(), 1'b1, 1'b0);
      push(aluwb_v, rb(), 1'b1, 1'b1);
    end else if (op == OP_I) begin
      push(v(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, exp_alu(op, f3, f7), 0), rb(), 1'b1, 1'b0);
      push(aluwb_v, rb(), 1'b1, 1'b1);
    end else if (op == OP_JAL) begin
      push(v(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000, 0), rb(), 1'b1, 1'b0);
      push(aluwb_v, rb(), 1'b1, 1'b1);
    end else if (op == OP_BEQ) begin
      push(v(z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 0), rb(), 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < ic; i++)
        push(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1), rb(), 1'b1, 1'b0);
      push(rst_v, rb(), 1'b0, 1'b0);
    end
  endtask

  // Driver: apply one queued cycle per clock, just after the rising edge.
  task automatic play();
    while (exp_q.size() > 0) begin
      cur_exp     = exp_q.pop_front();
      mem_ready_i = rdy_q.pop_front();
      rst_ni      = rstn_q.pop_front();
      cur_ret     = ret_q.pop_front();
      {op_i, funct3_i, funct7b5_i, zero_i} = fld_q.pop_front();
      chk = 1'b1;
      @(posedge clk);
      #1;
    end
    chk = 1'b0;
  endtask

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      if (dut_vec !== cur_exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got %b, expected %b (rst_ni=%b ready=%b op=%b)",
                 $time, dut_vec, cur_exp, rst_ni, mem_ready_i, op_i);
      end
`ifdef MCTRL_PERF_EN
      if (perf_valid) begin
        vectors++;
        if (cycle_o !== m_cyc || instret_o !== m_ret) begin
          miscompares++;
          $display("FAIL perf t=%0t: got cycle=%0d instret=%0d, expected cycle=%0d instret=%0d",
                   $time, cycle_o, instret_o, m_cyc, m_ret);
        end
      end
      if (!rst_ni) begin
        m_cyc = '0;
        m_ret = '0;
        perf_valid = 1'b1;
      end else begin
        m_cyc = m_cyc + PW'(1);
        if (cur_ret) m_ret = m_ret + PW'(1);
      end
`endif
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int cnt;
    logic [6:0] rop;
    rst_ni = 1'b0; op_i = '0; funct3_i = '0; funct7b5_i = 1'b0; zero_i = 1'b0;
    mem_ready_i = 1'b0; bld_fld = '0;
    @(posedge clk);
    #1;
    push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0), 1'b1, 1'b0, 1'b0);
    push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0), 1'b0, 1'b0, 1'b0);
    play();

    // add: 4 cycles, EXEC_R with alu add.
    gen(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    pin("add_len", exp_q.size(), 4);
    pin("add_exec_vec", int'(exp_q[2]), int'(15'b000001000000000));
    play();

    // lw with two memory-wait cycles: 7 cycles total, MEMWB last.
    gen(OP_LW, 3'b010, 1'b0, 1'b0, 0, 2, 0, 1'b0);
    pin("lw_len", exp_q.size(), 7);
    pin("lw_memwb_vec", int'(exp_q[6]), int'(15'b000010000010000));
    play();

    // beq taken then not taken.
    gen(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    pin("beq_len", exp_q.size(), 3);
    play();
    gen(OP_BEQ, 3'b000, 1'b0, 1'b0, 1, 0, 0, 1'b0);
    play();

    // sw with three wait cycles: four mem_write cycles.
    gen(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3, 0, 1'b0);
    cnt = 0;
    foreach (exp_q[i]) if (exp_q[i][11] && exp_q[i][12]) cnt++;
    pin("sw_mw_cycles", cnt, 4);
    play();

    // Assorted ALU ops and jal.
    gen(OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    gen(OP_I,   3'b000, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    gen(OP_R,   3'b010, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    gen(OP_I,   3'b110, 1'b0, 1'b0, 2, 0, 0, 1'b0);
    gen(OP_R,   3'b111, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    gen(OP_I,   3'b001, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    gen(OP_JAL, 3'b000, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    gen(OP_SW,  3'b010, 1'b0, 1'b0, 0, 2, 0, 1'b1);
    gen(OP_R,   3'b000, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    play();

    // Randomised instruction stream.
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 12);
      case (k)
        0, 1:    gen(OP_LW, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 3),
                     $urandom_range(0, 3), 0, 1'b0);
        2, 3:    gen(OP_SW, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 3),
                     $urandom_range(0, 3), 0, ($urandom_range(0, 7) == 0));
        4, 5:    gen(OP_R, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 2), 0, 0, 1'b0);
        6, 7:    gen(OP_I, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 2), 0, 0, 1'b0);
        8:       gen(OP_JAL, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 2), 0, 0, 1'b0);
        9, 10:   gen(OP_BEQ, 3'($urandom_range(0, 7)), rb(), rb(), $urandom_range(0, 2), 0, 0, 1'b0);
        default: begin
          rop = 7'($urandom_range(0, 127));
          while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
          gen(rop, 3'($urandom_range(0, 7)), rb(), rb(), 0, 0, $urandom_range(1, 4), 1'b0);
        end
      endcase
      play();
    end

    // Illegal opcode held for 10 cycles, then reset, then 17 adds.
    gen(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 10, 1'b0);
    play();
    for (int n = 0; n < 17; n++) gen(OP_R, 3'b000, 1'b0, rb(), 0, 0, 0, 1'b0);
    play();
`ifdef MCTRL_PERF_EN
    pin("instret_wrap", int'(instret_o), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
